race_director: RTL

Top-level race sequencer: it drives the 3-bit `state` bus and the engine reset consumed by both car physics engines, and collects their `finish` and `flag` outputs. It owns the 60 Hz game tick, the 3-2-1 countdown, the race clock (min:sec:frame), leader tracking, winner decision and the result hold-off. It sits between the debounced start button and the two player physics engines, and feeds the HUD/renderer.

---
 rtl/race_director_if.sv | 30 +++
 rtl/race_director.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/race_director_if.sv
// Bus between the race director, the two car engines and the HUD: start/finish/flag
// inputs toward the director, race state, timer and result outputs away from it.
interface race_director_if;
    logic       start_btn;
    logic       finish_p1;
    logic       finish_p2;
    logic [1:0] flag_p1;
    logic [1:0] flag_p2;
    logic [2:0] state;
    logic       engine_rst;
    logic       game_tick;
    logic [1:0] countdown;
    logic [3:0] race_min;
    logic [5:0] race_sec;
    logic [5:0] race_frame;
    logic [1:0] leader;
    logic [1:0] winner;

    modport master (
        input  start_btn, finish_p1, finish_p2, flag_p1, flag_p2,
        output state, engine_rst, game_tick, countdown,
               race_min, race_sec, race_frame, leader, winner
    );

    modport slave (
        output start_btn, finish_p1, finish_p2, flag_p1, flag_p2,
        input  state, engine_rst, game_tick, countdown,
               race_min, race_sec, race_frame, leader, winner
    );
endinterface

// File: rtl/race_director.sv
// Race sequencer: 60 Hz tick, 3-2-1 countdown, min:sec:frame race clock,
// leader tracking, winner decision and the post-race restart hold-off.
module race_director #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int COUNT_TICKS  = 60,
    parameter int RESULT_TICKS = 180
) (
    input  logic            clk,
    input  logic            rst,
    race_director_if.master bus
);
    localparam int TICK_DIV = CLK_FREQ / 60;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STEP_MAX = (COUNT_TICKS > RESULT_TICKS) ? COUNT_TICKS : RESULT_TICKS;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] COUNT_LAST = STEP_W'(COUNT_TICKS - 1);
    localparam logic [STEP_W-1:0] RESULT_END = STEP_W'(RESULT_TICKS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT3   = 3'd1,
        CNT2   = 3'd2,
        CNT1   = 3'd3,
        RACE   = 3'd4,
        RESULT = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [STEP_W-1:0] r_step, w_step_nxt;
    logic              r_btn_prev;
    logic              r_tick, w_tick_nxt;
    logic              r_engine_rst, w_engine_rst_nxt;
    logic [1:0]        r_countdown, w_countdown_nxt;
    logic [3:0]        r_min, w_min_nxt;
    logic [5:0]        r_sec, w_sec_nxt;
    logic [5:0]        r_frame, w_frame_nxt;
    logic [1:0]        r_leader, w_leader_nxt;
    logic [1:0]        r_winner, w_winner_nxt;
    logic              w_start_edge, w_restart, w_illegal;
    logic              w_timer_max, w_count_done, w_finish;

    always_comb begin
        w_start_edge     = bus.start_btn & ~r_btn_prev;
        w_finish         = bus.finish_p1 | bus.finish_p2;
        w_timer_max      = (r_min == 4'd9) && (r_sec == 6'd59) && (r_frame == 6'd59);
        w_count_done     = r_tick && (r_step == COUNT_LAST);
        w_state_nxt      = r_state;
        w_step_nxt       = r_step;
        w_min_nxt        = r_min;
        w_sec_nxt        = r_sec;
        w_frame_nxt      = r_frame;
        w_leader_nxt     = r_leader;
        w_winner_nxt     = r_winner;
        w_engine_rst_nxt = 1'b0;
        w_restart        = 1'b0;
        w_illegal        = 1'b0;

        case (r_state)
            IDLE: w_restart = w_start_edge;
            CNT3, CNT2, CNT1: begin
                if (r_tick)
                    w_step_nxt = w_count_done ? '0 : r_step + 1'b1;
                if (w_count_done)
                    w_state_nxt = (r_state == CNT3) ? CNT2 :
                                  (r_state == CNT2) ? CNT1 : RACE;
            end
            RACE: begin
                if (bus.flag_p1 > bus.flag_p2)
                    w_leader_nxt = 2'd1;
                else if (bus.flag_p2 > bus.flag_p1)
                    w_leader_nxt = 2'd2;
                // A finish freezes the clock as it stands, even on a tick cycle
                if (w_finish) begin
                    w_winner_nxt = {bus.finish_p2, bus.finish_p1};
                    w_state_nxt  = RESULT;
                    w_step_nxt   = '0;
                end else if (r_tick) begin
                    if (w_timer_max) begin
                        w_winner_nxt = 2'd3;
                        w_state_nxt  = RESULT;
                        w_step_nxt   = '0;
                    end else if (r_frame != 6'd59) begin
                        w_frame_nxt = r_frame + 6'd1;
                    end else begin
                        w_frame_nxt = '0;
                        if (r_sec != 6'd59) begin
                            w_sec_nxt = r_sec + 6'd1;
                        end else begin
                            w_sec_nxt = '0;
                            w_min_nxt = r_min + 4'd1;
                        end
                    end
                end
            end
            RESULT: begin
                if (r_tick && (r_step < RESULT_END))
                    w_step_nxt = r_step + 1'b1;
                w_restart = w_start_edge && (r_step >= RESULT_END);
            end
            default: begin
                w_illegal    = 1'b1;
                w_state_nxt  = IDLE;
                w_step_nxt   = '0;
                w_min_nxt    = '0;
                w_sec_nxt    = '0;
                w_frame_nxt  = '0;
                w_leader_nxt = '0;
                w_winner_nxt = '0;
            end
        endcase

        if (w_restart) begin
            w_engine_rst_nxt = 1'b1;
            w_state_nxt      = CNT3;
            w_step_nxt       = '0;
            w_min_nxt        = '0;
            w_sec_nxt        = '0;
            w_frame_nxt      = '0;
            w_leader_nxt     = '0;
            w_winner_nxt     = '0;
        end

        // Restarting the divider on a start edge aligns the countdown to the press
        w_div_nxt  = (w_restart || w_illegal || (r_div == DIV_LAST)) ? '0 : r_div + 1'b1;
        w_tick_nxt = !w_illegal && (w_div_nxt == DIV_LAST);

        case (w_state_nxt)
            CNT3:    w_countdown_nxt = 2'd3;
            CNT2:    w_countdown_nxt = 2'd2;
            CNT1:    w_countdown_nxt = 2'd1;
            default: w_countdown_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_step       <= '0;
            r_btn_prev   <= 1'b0;
            r_tick       <= 1'b0;
            r_engine_rst <= 1'b0;
            r_countdown  <= '0;
            r_min        <= '0;
            r_sec        <= '0;
            r_frame      <= '0;
            r_leader     <= '0;
            r_winner     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_step       <= w_step_nxt;
            r_btn_prev   <= bus.start_btn;
            r_tick       <= w_tick_nxt;
            r_engine_rst <= w_engine_rst_nxt;
            r_countdown  <= w_countdown_nxt;
            r_min        <= w_min_nxt;
            r_sec        <= w_sec_nxt;
            r_frame      <= w_frame_nxt;
            r_leader     <= w_leader_nxt;
            r_winner     <= w_winner_nxt;
        end
    end

    assign bus.state      = r_state;
    assign bus.engine_rst = r_engine_rst;
    assign bus.game_tick  = r_tick;
    assign bus.countdown  = r_countdown;
    assign bus.race_min   = r_min;
    assign bus.race_sec   = r_sec;
    assign bus.race_frame = r_frame;
    assign bus.leader     = r_leader;
    assign bus.winner     = r_winner;
endmodule
